// File: rtl/rom_scan_pkg.sv
// Shared defaults and state type for the ROM row scanner.
package rom_scan_pkg;

  localparam int DEF_ROWS         = 48;
  localparam int DEF_WIDTH        = 64;
  localparam int DEF_ADDR_W       = 6;
  localparam int DEF_BLANK_CYCLES = 4;
  localparam int BLANK_CNT_W      = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SHIFT = 3'd2,
    BLANK = 3'd3,
    DONE  = 3'd4
  } scan_state_t;

endpackage

// File: rtl/row_shifter.sv
// Row-wide shift register: parallel load, left shift with zero fill, MSB out.
module row_shifter
  import rom_scan_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] shreg_r;

  // Shift register: load has priority over shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_r <= '0;
    end else if (load) begin
      shreg_r <= din;
    end else if (shift_en) begin
      shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
    end else begin
      shreg_r <= shreg_r;
    end
  end

  assign msb = shreg_r[WIDTH-1];

endmodule

// File: rtl/rom_row_scanner.sv
// Walks the bitmap ROM row by row and streams each row MSB-first as a
// one-bit pixel stream under valid/ready, with a blank gap between rows.
module rom_row_scanner
  import rom_scan_pkg::*;
#(
  parameter int ROWS         = DEF_ROWS,
  parameter int WIDTH        = DEF_WIDTH,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WIDTH-1:0]  rom_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_data,
  output logic [ADDR_W-1:0] pix_col,
  output logic [ADDR_W-1:0] pix_row,
  output logic              sol,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0]      LAST_ROW   = ADDR_W'(ROWS - 32'sd1);
  localparam logic [ADDR_W-1:0]      LAST_COL   = ADDR_W'(WIDTH - 32'sd1);
  localparam logic [ADDR_W-1:0]      ADDR_ONE   = ADDR_W'(32'd1);
  localparam logic [BLANK_CNT_W-1:0] BLANK_LAST = BLANK_CNT_W'(BLANK_CYCLES - 32'sd1);
  localparam logic [BLANK_CNT_W-1:0] CNT_ONE    = BLANK_CNT_W'(32'd1);
  localparam bit                     HAS_BLANK  = (BLANK_CYCLES > 32'sd0);

  scan_state_t            state_r, state_s;
  logic [ADDR_W-1:0]      row_r, row_s;
  logic [ADDR_W-1:0]      col_r, col_s;
  logic [BLANK_CNT_W-1:0] cnt_r, cnt_s;
  logic                   load_s, shift_s, accept_s;
  logic                   pix_valid_r, sol_r, busy_r, frame_done_r;

  assign accept_s = pix_valid_r & pix_ready;

  // Next-state, row/column/blank counter and shifter control.
  always_comb begin
    state_s = state_r;
    row_s   = row_r;
    col_s   = col_r;
    cnt_s   = cnt_r;
    load_s  = 1'b0;
    shift_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = FETCH;
          row_s   = '0;
          col_s   = '0;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        load_s  = 1'b1;
        col_s   = '0;
        state_s = SHIFT;
      end
      SHIFT: begin
        if (accept_s) begin
          shift_s = 1'b1;
          col_s   = col_r + ADDR_ONE;
          if (col_r == LAST_COL) begin
            col_s = '0;
            if (row_r == LAST_ROW) begin
              state_s = DONE;
            end else if (HAS_BLANK) begin
              state_s = BLANK;
              cnt_s   = '0;
            end else begin
              state_s = FETCH;
              row_s   = row_r + ADDR_ONE;
            end
          end else begin
            state_s = SHIFT;
          end
        end else begin
          state_s = SHIFT;
        end
      end
      BLANK: begin
        if (cnt_r == BLANK_LAST) begin
          state_s = FETCH;
          row_s   = row_r + ADDR_ONE;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      DONE: begin
        state_s = IDLE;
        row_s   = '0;
        col_s   = '0;
      end
      default: begin
        state_s = IDLE;
        row_s   = '0;
        col_s   = '0;
        cnt_s   = '0;
      end
    endcase
  end

  // State and output registers; outputs are decoded from the next state so
  // they line up with the cycle the FSM is in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      row_r        <= '0;
      col_r        <= '0;
      cnt_r        <= '0;
      pix_valid_r  <= 1'b0;
      sol_r        <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      row_r        <= row_s;
      col_r        <= col_s;
      cnt_r        <= cnt_s;
      pix_valid_r  <= (state_s == SHIFT);
      sol_r        <= (state_s == SHIFT) && (col_s == '0);
      busy_r       <= (state_s != IDLE);
      frame_done_r <= (state_s == DONE);
    end
  end

  row_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_s),
    .shift_en (shift_s),
    .din      (rom_data),
    .msb      (pix_data)
  );

  assign rom_addr   = row_r;
  assign pix_valid  = pix_valid_r;
  assign pix_col    = col_r;
  assign pix_row    = row_r;
  assign sol        = sol_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_rom_row_scanner.sv
// Bench for rom_row_scanner: startup vector table, hand-written frame
// sequences and a frame-level model of the expected pixel stream.
module tb_rom_row_scanner;

  localparam int ROWS      = 48;
  localparam int WIDTH     = 64;
  localparam int ADDR_W    = 6;
  localparam int BLANK     = 4;
  localparam int FRAME_LEN = ROWS * (1 + WIDTH) + (ROWS - 1) * BLANK + 1;
  localparam int BEATS     = ROWS * WIDTH;

  logic              clk = 1'b0;
  logic              rst_n, start, pix_ready;
  logic [ADDR_W-1:0] rom_addr, pix_col, pix_row;
  logic [WIDTH-1:0]  rom_data;
  logic              pix_valid, pix_data, sol, busy, frame_done;
  logic [22:0]       outs;

  logic [WIDTH-1:0]  rom_mem [ROWS];

  int total = 0, bad = 0;
  int cyc = 0, st_cyc = 0, ready_mode = 0;
  int beat_idx = 0, done_cnt = 0, done_cyc = 0, ones15 = 0, max_row = 0, last_acc = 0;
  bit prev_stall = 1'b0, prev_busy = 1'b0;
  logic [13:0] held = '0;

  typedef struct {
    bit         rdy;
    logic       v;
    logic       d;
    logic [5:0] col;
    logic       sol;
    logic       busy;
  } vec_t;
  vec_t vecs [8];

  always #5 clk = ~clk;

  assign rom_data = (int'(rom_addr) < ROWS) ? rom_mem[rom_addr] : '0;
  assign outs = {rom_addr, pix_valid, pix_data, pix_col, pix_row, sol, busy, frame_done};

  rom_row_scanner #(
    .ROWS(ROWS), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .BLANK_CYCLES(BLANK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_col(pix_col), .pix_row(pix_row), .sol(sol), .busy(busy), .frame_done(frame_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stream model: beat k of a frame is row k/WIDTH, column k%WIDTH, MSB-first.
  task automatic monitor();
    int r, c;
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_busy  = 1'b0;
    end else begin
      if (busy && !prev_busy) begin
        beat_idx = 0; done_cnt = 0; ones15 = 0; max_row = 0;
      end
      prev_busy = busy;
      if (prev_stall)
        check("stall_hold", {pix_valid, pix_data, pix_col, pix_row, sol}, {1'b1, held});
      if (pix_valid && pix_ready) begin
        if (beat_idx < BEATS) begin
          r = beat_idx / WIDTH;
          c = beat_idx % WIDTH;
          check("beat", {pix_data, pix_row, pix_col, sol},
                {rom_mem[r][WIDTH-1-c], 6'(r), 6'(c), (c == 0)});
          if (c == 0 && r > 0 && ready_mode == 1)
            check("row_gap", 64'(cyc - last_acc), 64'(BLANK + 2));
          if (r == 15 && pix_data) ones15++;
        end else begin
          check("extra_beat", 64'(beat_idx), 64'(BEATS - 1));
        end
        if (int'(pix_row) > max_row) max_row = int'(pix_row);
        last_acc = cyc;
        beat_idx++;
      end
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = pix_valid && !pix_ready;
      held = {pix_data, pix_col, pix_row, sol};
    end
  endtask

  task automatic tick(input bit rdy_in);
    @(posedge clk);
    cyc++;
    #1;
    case (ready_mode)
      1:       pix_ready = 1'b1;
      2:       pix_ready = ($urandom_range(99, 0) < 30);
      default: pix_ready = rdy_in;
    endcase
    @(negedge clk);
    monitor();
  endtask

  task automatic pulse_start();
    start  = 1'b1;
    st_cyc = cyc;
    tick(1'b1);
    start  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick(1'b1);
      n++;
    end
    check("done_seen", 64'(done_cnt), 64'd1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; pix_ready = 1'b0;
    for (int i = 0; i < ROWS; i++) rom_mem[i] = {$urandom(), $urandom()};
    rom_mem[0]  = 64'h18000F83E1F83E0F;
    rom_mem[15] = '1;
    // FETCH, a one-cycle stall on beat 0, then beats 0..5 = 0,0,0,1,1,0
    vecs[0] = '{1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 6'd0, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 6'd0, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 6'd1, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 6'd2, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 6'd3, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 6'd4, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 6'd5, 1'b0, 1'b1};

    // reset with start held high, then idle
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0);
      check("reset_outs", 64'(outs), 64'd0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0);
      check("idle_outs", 64'(outs), 64'd0);
    end

    // startup vector table, rest of the frame always ready
    ready_mode = 0;
    start  = 1'b1;
    st_cyc = cyc;
    for (int i = 0; i < 8; i++) begin
      tick(vecs[i].rdy);
      start = 1'b0;
      check($sformatf("vec%0d", i), 64'(outs),
            64'({6'd0, vecs[i].v, vecs[i].d, vecs[i].col, 6'd0, vecs[i].sol, vecs[i].busy, 1'b0}));
    end
    ready_mode = 1;
    wait_done(5000);
    check("len_one_stall", 64'(done_cyc - st_cyc), 64'(FRAME_LEN + 1));
    check("beats_first", 64'(beat_idx), 64'(BEATS));

    // full frame, always ready
    for (int i = 0; i < 3; i++) tick(1'b1);
    pulse_start();
    wait_done(5000);
    check("frame_len", 64'(done_cyc - st_cyc), 64'(FRAME_LEN));
    check("beats_full", 64'(beat_idx), 64'(BEATS));
    check("row15_ones", 64'(ones15), 64'd64);
    check("max_row", 64'(max_row), 64'(ROWS - 1));
    for (int i = 0; i < 5; i++) tick(1'b1);
    check("single_done", 64'(done_cnt), 64'd1);
    check("idle_after", 64'(busy), 64'd0);

    // start pulses mid-row 5 and in the DONE cycle are ignored
    pulse_start();
    n = 0;
    while (beat_idx < 5 * WIDTH + 10 && n < 2000) begin
      tick(1'b1);
      n++;
    end
    check("row5_reached", 64'(pix_row), 64'd5);
    start = 1'b1;
    tick(1'b1);
    start = 1'b0;
    wait_done(5000);
    check("done_state", 64'(frame_done), 64'd1);
    start = 1'b1;
    tick(1'b1);
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick(1'b1);
    check("busy_start_len", 64'(done_cyc - st_cyc), 64'(FRAME_LEN));
    check("busy_start_done", 64'(done_cnt), 64'd1);
    check("busy_start_idle", 64'(busy), 64'd0);
    check("busy_start_beats", 64'(beat_idx), 64'(BEATS));

    // random backpressure, ~30% ready
    ready_mode = 2;
    pulse_start();
    wait_done(30000);
    check("bp_beats", 64'(beat_idx), 64'(BEATS));
    ready_mode = 1;
    for (int i = 0; i < 3; i++) tick(1'b1);

    // reset at row 20 col 33, then restart
    pulse_start();
    n = 0;
    while (!(pix_valid && pix_row == 6'd20 && pix_col == 6'd33) && n < 3000) begin
      tick(1'b1);
      n++;
    end
    check("reach_r20c33", 64'({pix_row, pix_col}), 64'({6'd20, 6'd33}));
    rst_n = 1'b0;
    #1;
    check("abort_outs", 64'({pix_valid, busy, frame_done, rom_addr}), 64'd0);
    for (int i = 0; i < 3; i++) tick(1'b1);
    check("abort_no_done", 64'(done_cnt), 64'd0);
    rst_n = 1'b1;
    tick(1'b1);
    pulse_start();
    check("restart_fetch", 64'({rom_addr, busy, pix_valid}), 64'({6'd0, 1'b1, 1'b0}));
    wait_done(5000);
    check("restart_len", 64'(done_cyc - st_cyc), 64'(FRAME_LEN));
    check("restart_beats", 64'(beat_idx), 64'(BEATS));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_row_scanner.md
# rom_row_scanner

Upstream address generator and downstream serializer for the 48-row by 64-bit bitmap ROM. On a start pulse it walks ROM addresses 0 to ROWS-1 and registers each 64-bit row. It shifts the row out MSB-first as a one-bit pixel stream under a valid/ready handshake, with a programmable blank gap between rows. It sits between the frame controller (start) and the pixel sink (display/LED driver).

## Interface
- ROWS, 48, number of ROM rows scanned per frame
- WIDTH, 64, bits per ROM row
- ADDR_W, 6, ROM address width
- BLANK_CYCLES, 4, idle cycles inserted between rows (legal range 0..15)

- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle frame start request
- rom_addr  out  ADDR_W  address driven to the combinational ROM
- rom_data  in  WIDTH  ROM word for rom_addr, valid same cycle
- pix_valid  out  1  pixel beat valid
- pix_ready  in  1  sink accepts beat
- pix_data  out  1  current pixel bit
- pix_col  out  ADDR_W  column index of current beat (0..WIDTH-1)
- pix_row  out  ADDR_W  row index of current beat (0..ROWS-1)
- sol  out  1  high with the col-0 beat of each row
- busy  out  1  high from FETCH of row 0 through DONE
- frame_done  out  1  one-cycle pulse after the last beat of row ROWS-1

## Operation
- FSM states: IDLE, FETCH, SHIFT, BLANK, DONE.
- IDLE: `start`=1 -> FETCH with row=0. Otherwise stay in IDLE.
- FETCH (1 cycle): rom_addr=row. The shift register loads rom_data and col is cleared to 0. Next state is SHIFT.
- SHIFT: pix_valid=1 and pix_data=shreg[WIDTH-1]. A beat is accepted when pix_valid && pix_ready. On accept, shreg shifts left by 1, zero-filled, and col increments.
- Accept at col=WIDTH-1:
  - if row=ROWS-1 -> DONE
  - else if BLANK_CYCLES=0 -> FETCH with row+1
  - else -> BLANK
- BLANK: a counter counts BLANK_CYCLES cycles, then -> FETCH with row+1.
- DONE (1 cycle): frame_done=1, then -> IDLE. Row and col return to 0.
- `start` is ignored when the FSM is not in IDLE (including DONE); there is no queuing.
- Outside FETCH, rom_addr holds the current row.
- Handshake:
  - while pix_valid && !pix_ready, the values of pix_data, pix_col, pix_row and sol are held stable;
  - pix_valid never drops without an accept.
- Asserting rst_n low mid-frame aborts immediately; there is no frame_done pulse.

## Timing
- Reset values: rom_addr=0, pix_valid=0, pix_data=0, pix_col=0, pix_row=0, sol=0, busy=0, frame_done=0, state=IDLE.
- `start` sampled at edge N gives FETCH in cycle N+1. The first beat is valid in cycle N+2 (latency 2).
- Per-row cost with pix_ready held at 1: 1 FETCH + WIDTH beats + BLANK_CYCLES.
- Frame length with pix_ready held at 1: ROWS·(1+WIDTH) + (ROWS-1)·BLANK_CYCLES + 1 DONE cycle. Defaults give 48·65 + 47·4 + 1 = 3309 cycles.
- The frame_done pulse occurs in the cycle after the final accept.
- All outputs are registered except pix_data, which is the MSB of the registered shreg.

## Structure
- Package `rom_scan_pkg` holds:
  - ROWS, WIDTH, ADDR_W defaults;
  - `scan_state_t` enum {IDLE, FETCH, SHIFT, BLANK, DONE};
  - the BLANK counter width constant (4).
- Single module with no sub-module beyond the 64-bit shift register.
- The shift register may be split out as `row_shifter` (load, shift enable, msb out).

## Test plan
- Reset then idle: hold rst_n=0 and then release it, with no start. All outputs stay 0 for 20 cycles; `start` asserted while rst_n=0 has no effect.
- Single row, always ready: ROM model returns 64'h18000F83E1F83E0F for row 0. With `start` at cycle 10, FETCH occurs at cycle 11 with rom_addr=0. From cycle 12 the first six pix_data values are 0,0,0,1,1,0. sol=1 only at col 0.
- Full frame, always ready, defaults: frame_done pulses exactly once, 3309 cycles after `start`. Exactly 3072 beats are accepted and pix_row runs 0..47. There are exactly 4 idle cycles between rows. Row 15 (all ones) yields 64 ones.
- Backpressure: pix_ready is random at 30% high. The captured bitstream equals the ROM contents MSB-first. Payload is stable during stalls, with no beat lost or duplicated.
- Start while busy: pulse `start` mid-row 5 and again in the DONE cycle. Both are ignored: frame length is unchanged and exactly one frame_done is produced.
- Reset mid-frame: drop rst_n during row 20 col 33. pix_valid=0 and busy=0 immediately, with no frame_done. A new `start` begins again at rom_addr=0.
